cva6_axi_spm_resp: RTL and testbench
====================================

CVA6_AXI_SPM_RESP -- requirements
Module: cva6_axi_spm_resp

Interface
REQ-001 SHALL have parameter IdWidth, default 4, meaning the AXI ID width.
REQ-002 SHALL have parameter NumWords, default 4096 (power of two), meaning the number of 64-bit words stored (32 KiB).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have the AW group: aw_valid_i in 1, aw_ready_o out 1, aw_id_i in IdWidth, aw_addr_i in 64, aw_len_i in 8, aw_burst_i in 2; a write-address request.
REQ-006 SHALL have the W group: w_valid_i in 1, w_ready_o out 1, w_data_i in 64, w_strb_i in 8, w_last_i in 1; write data beats.
REQ-007 SHALL have the B group: b_valid_o out 1, b_ready_i in 1, b_id_o out IdWidth, b_resp_o out 2; the write response.
REQ-008 SHALL have the AR group: ar_valid_i in 1, ar_ready_o out 1, ar_id_i in IdWidth, ar_addr_i in 64, ar_len_i in 8, ar_burst_i in 2; a read-address request.
REQ-009 SHALL have the R group: r_valid_o out 1, r_ready_i in 1, r_id_o out IdWidth, r_data_o out 64, r_resp_o out 2, r_last_o out 1; read data beats.

Function
REQ-010 SHALL be the AXI4 responder end of the core's 64-bit data port; it serves one transaction at a time.
REQ-011 SHALL implement the FSM IDLE, WDATA, WRESP, RDATA.
- IDLE: aw_ready_o and ar_ready_o asserted. A handshake on AW moves to WDATA; a handshake on AR moves to RDATA.
REQ-012 SHALL, when AW and AR are both valid in IDLE, accept the channel not served last; the first tie after reset goes to read. Only the chosen ready is asserted that cycle.
REQ-013 SHALL compute word index = aw/ar_addr_i[3+log2(NumWords)-1:3]; address bits [2:0] are ignored and the size is always treated as 8 bytes.
REQ-014 SHALL advance the index by 1 per beat for burst INCR (01); FIXED (00) keeps it constant; WRAP (10) and reserved (11) are treated as INCR. The index wraps modulo NumWords.
REQ-015 SHALL, in WDATA, assert w_ready_o; each W handshake writes the bytes whose w_strb_i bit is 1.
- The w_last_i beat moves to WRESP.
- Beats after len+1 without w_last_i are still accepted until w_last_i arrives.
- An early w_last_i ends the burst.
REQ-016 SHALL, in WRESP, hold b_valid_o=1 with the latched ID until b_ready_i, then return to IDLE; b_resp_o=OKAY (00) unless REQ-024 applies.
REQ-017 SHALL, in RDATA, present beat 0 with r_valid_o=1 one cycle after the AR handshake; r_id_o, r_data_o and r_last_o are stable while r_valid_o=1 and r_ready_i=0.
REQ-018 SHALL, when r_ready_i stays high, deliver one beat per cycle; r_last_o=1 on beat len. Its handshake returns to IDLE with r_valid_o=0 the next cycle.
REQ-019 SHALL give a read of a word written by an earlier completed write (B handshake done) the new data.
REQ-020 SHALL keep all other outputs 0 when not in the state that drives them.

Reset
REQ-021 SHALL, on rst_i=1 at a clock edge, enter IDLE and clear the following: aw_ready_o, ar_ready_o (then 1 in IDLE after release), w_ready_o, b_valid_o, r_valid_o, r_last_o, b_resp_o, r_resp_o, b_id_o, r_id_o, r_data_o and the tie-break flag.
REQ-022 SHALL abandon any transaction in progress when reset is asserted mid-burst, with no further B or R beats. Memory contents are not cleared.
REQ-023 SHALL treat rst_i as sampled only at the clock edge; there is no asynchronous path.

Configuration
REQ-024 SHALL, with macro CVA6_AXI_SPM_ERR_RESP_EN defined, check addresses on accept.
- A request with aw/ar_addr_i >= NumWords*8 is marked error.
- Error write: W beats are consumed without writing memory, and b_resp_o=SLVERR (10).
- Error read: returns len+1 beats with r_data_o=0 and r_resp_o=SLVERR (10).
REQ-025 SHALL, without the macro, ignore upper address bits (aliasing) and always respond OKAY (00).

Verification
REQ-026 SHALL pass: AW id=3 addr=0x10 len=1 INCR, then W 0x1111, 0x2222 strb=FF -> B id=3 OKAY; AR addr=0x10 len=1 -> R 0x1111, 0x2222 with r_last_o on beat 2.
REQ-027 SHALL pass: word 0 = all-ones, write 0x0 with strb=0x0F -> read returns 0xFFFFFFFF_00000000.
REQ-028 SHALL pass: AR len=3 with r_ready_i low for 3 cycles on beat 1 -> beat 1 data held stable, 4 beats total, r_last_o only on the last.
REQ-029 SHALL pass: AW and AR valid together right after reset -> read served first; on the next tie, write served first.
REQ-030 SHALL pass: rst_i pulsed mid-read on beat 2 of len=7 -> r_valid_o=0 the next cycle, then IDLE, and a new AR is accepted.
REQ-031 SHALL pass: with CVA6_AXI_SPM_ERR_RESP_EN, AR addr=NumWords*8 len=0 -> one R beat with SLVERR, data 0; without the macro -> data of word 0 with OKAY.

Source files
------------

// File: rtl/cva6_axi_spm_resp.sv
// AXI4 responder scratchpad: 64-bit word memory that serves one AW/W/B or AR/R transaction at a time.
// Latency: first R beat one cycle after the AR handshake, one beat per cycle after that; B one cycle after the last W beat.
// Backpressure: R and B outputs hold steady while their ready is low; when AW and AR arrive together, only one ready is raised.
//
// Ports:
//   clk_i, rst_i             - clock and synchronous active-high reset
//   aw_* / w_* / b_*         - AXI4 write address, write data, write response
//   ar_* / r_*               - AXI4 read address, read data
// Parameters: IdWidth (AXI ID width), NumWords (64-bit words stored, power of two).
// Build option: define CVA6_AXI_SPM_ERR_RESP_EN to answer out-of-range addresses with SLVERR
// (writes dropped, reads return zero). Without it, upper address bits alias and every response is OKAY.

module cva6_axi_spm_resp #(
    parameter int unsigned IdWidth  = 4,
    parameter int unsigned NumWords = 4096
) (
    input  logic               clk_i,
    input  logic               rst_i,
    // write address
    input  logic               aw_valid_i,
    output logic               aw_ready_o,
    input  logic [IdWidth-1:0] aw_id_i,
    input  logic [63:0]        aw_addr_i,
    input  logic [7:0]         aw_len_i,
    input  logic [1:0]         aw_burst_i,
    // write data
    input  logic               w_valid_i,
    output logic               w_ready_o,
    input  logic [63:0]        w_data_i,
    input  logic [7:0]         w_strb_i,
    input  logic               w_last_i,
    // write response
    output logic               b_valid_o,
    input  logic               b_ready_i,
    output logic [IdWidth-1:0] b_id_o,
    output logic [1:0]         b_resp_o,
    // read address
    input  logic               ar_valid_i,
    output logic               ar_ready_o,
    input  logic [IdWidth-1:0] ar_id_i,
    input  logic [63:0]        ar_addr_i,
    input  logic [7:0]         ar_len_i,
    input  logic [1:0]         ar_burst_i,
    // read data
    output logic               r_valid_o,
    input  logic               r_ready_i,
    output logic [IdWidth-1:0] r_id_o,
    output logic [63:0]        r_data_o,
    output logic [1:0]         r_resp_o,
    output logic               r_last_o
);

    localparam int unsigned IdxW = $clog2(NumWords);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WDATA = 2'd1;
    localparam logic [1:0] ST_WRESP = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]         state_q, state_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         beat_q, beat_d;
    logic               fixed_q, fixed_d;
    logic               err_q, err_d;
    logic               prefer_wr_q, prefer_wr_d;
    logic [IdWidth-1:0] id_q, id_d;
    logic [63:0]        rdata_q, rdata_d;

    logic [63:0]        mem_q [NumWords];

    logic               idle;
    logic               aw_hs, w_hs, ar_hs;
    logic               aw_err, ar_err;
    logic [IdxW-1:0]    aw_idx, ar_idx, idx_next;

    assign aw_idx   = aw_addr_i[3+IdxW-1:3];
    assign ar_idx   = ar_addr_i[3+IdxW-1:3];
    assign idx_next = fixed_q ? idx_q : idx_q + IdxW'(1);

`ifdef CVA6_AXI_SPM_ERR_RESP_EN
    assign aw_err = |aw_addr_i[63:3+IdxW];
    assign ar_err = |ar_addr_i[63:3+IdxW];
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    // Byte offset, upper alias bits and the write length carry no meaning here:
    // the write burst is terminated by w_last_i alone.
    logic unused_bits;
    assign unused_bits = ^{aw_addr_i[2:0], ar_addr_i[2:0], aw_addr_i[63:3+IdxW],
                           ar_addr_i[63:3+IdxW], aw_len_i};

    // Readies are gated by rst_i so nothing can be accepted on a reset edge.
    // On a tie only the channel not served last sees ready.
    assign idle       = (state_q == ST_IDLE) && !rst_i;
    assign aw_ready_o = idle && (!ar_valid_i || prefer_wr_q);
    assign ar_ready_o = idle && (!aw_valid_i || !prefer_wr_q);
    assign w_ready_o  = (state_q == ST_WDATA) && !rst_i;

    assign aw_hs = aw_valid_i && aw_ready_o;
    assign ar_hs = ar_valid_i && ar_ready_o;
    assign w_hs  = w_valid_i && w_ready_o;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        beat_d      = beat_q;
        fixed_d     = fixed_q;
        err_d       = err_q;
        prefer_wr_d = prefer_wr_q;
        id_d        = id_q;
        rdata_d     = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_d     = ST_RDATA;
                    id_d        = ar_id_i;
                    idx_d       = ar_idx;
                    len_d       = ar_len_i;
                    beat_d      = 8'd0;
                    fixed_d     = (ar_burst_i == 2'b00);
                    err_d       = ar_err;
                    prefer_wr_d = 1'b1;
                    rdata_d     = ar_err ? 64'd0 : mem_q[ar_idx];
                end else if (aw_hs) begin
                    state_d     = ST_WDATA;
                    id_d        = aw_id_i;
                    idx_d       = aw_idx;
                    fixed_d     = (aw_burst_i == 2'b00);
                    err_d       = aw_err;
                    prefer_wr_d = 1'b0;
                end
            end
            ST_WDATA: begin
                if (w_hs) begin
                    idx_d = idx_next;
                    if (w_last_i) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (b_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (r_ready_i) begin
                    if (beat_q == len_q) begin
                        state_d = ST_IDLE;
                        rdata_d = 64'd0;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        idx_d   = idx_next;
                        // Prefetch the next word so the beat is ready the following cycle.
                        rdata_d = err_q ? 64'd0 : mem_q[idx_next];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            fixed_q     <= 1'b0;
            err_q       <= 1'b0;
            prefer_wr_q <= 1'b0;
            id_q        <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            fixed_q     <= fixed_d;
            err_q       <= err_d;
            prefer_wr_q <= prefer_wr_d;
            id_q        <= id_d;
            rdata_q     <= rdata_d;
        end
    end

    // Storage is deliberately left out of reset; w_hs is already blocked during reset.
    always_ff @(posedge clk_i) begin
        if (w_hs && !err_q) begin
            for (int b = 0; b < 8; b++) begin
                if (w_strb_i[b]) begin
                    mem_q[idx_q][8*b +: 8] <= w_data_i[8*b +: 8];
                end
            end
        end
    end

    assign b_valid_o = (state_q == ST_WRESP);
    assign b_id_o    = b_valid_o ? id_q : '0;
    assign b_resp_o  = (b_valid_o && err_q) ? RESP_SLVERR : RESP_OKAY;

    assign r_valid_o = (state_q == ST_RDATA);
    assign r_id_o    = r_valid_o ? id_q : '0;
    assign r_data_o  = r_valid_o ? rdata_q : 64'd0;
    assign r_resp_o  = (r_valid_o && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign r_last_o  = r_valid_o && (beat_q == len_q);

endmodule

// File: tb/tb_cva6_axi_spm_resp.sv
// Self-checking bench for cva6_axi_spm_resp: directed AXI transactions with a word model
// and B/R scoreboards; inputs change and outputs are sampled on the falling clock edge.
module tb_cva6_axi_spm_resp;

    localparam int ID_W = 4;
    localparam int NW   = 4096;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_exp_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     data;
        logic [1:0]      resp;
        logic            last;
    } r_exp_t;

    logic            clk;
    logic            rst;
    logic            aw_valid, aw_ready_o;
    logic [ID_W-1:0] aw_id;
    logic [63:0]     aw_addr;
    logic [7:0]      aw_len;
    logic [1:0]      aw_burst;
    logic            w_valid, w_ready_o;
    logic [63:0]     w_data;
    logic [7:0]      w_strb;
    logic            w_last;
    logic            b_valid_o, b_ready;
    logic [ID_W-1:0] b_id_o;
    logic [1:0]      b_resp_o;
    logic            ar_valid, ar_ready_o;
    logic [ID_W-1:0] ar_id;
    logic [63:0]     ar_addr;
    logic [7:0]      ar_len;
    logic [1:0]      ar_burst;
    logic            r_valid_o, r_ready;
    logic [ID_W-1:0] r_id_o;
    logic [63:0]     r_data_o;
    logic [1:0]      r_resp_o;
    logic            r_last_o;

    int              n_asserts;
    int              n_fail;
    logic [63:0]     model [int];
    b_exp_t          b_q [$];
    r_exp_t          r_q [$];
    logic [63:0]     wd [16];
    logic [7:0]      ws [16];

    cva6_axi_spm_resp #(.IdWidth(ID_W), .NumWords(NW)) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id),
        .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_burst_i(aw_burst),
        .w_valid_i(w_valid), .w_ready_o(w_ready_o), .w_data_i(w_data),
        .w_strb_i(w_strb), .w_last_i(w_last),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id),
        .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_burst_i(ar_burst),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready), .r_id_o(r_id_o),
        .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_err(input logic [63:0] addr);
        bit e;
        e = 1'b0;
`ifdef CVA6_AXI_SPM_ERR_RESP_EN
        e = (addr >= 64'(NW * 8));
`endif
        return e;
    endfunction

    function automatic int word_idx(input logic [63:0] addr);
        return int'((addr >> 3) % 64'(NW));
    endfunction

    task automatic do_write(input logic [ID_W-1:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input int nbeats);
        int     idx;
        int     cyc;
        bit     err;
        b_exp_t be;
        logic [63:0] tmp;
        err     = addr_err(addr);
        idx     = word_idx(addr);
        be.id   = id;
        be.resp = err ? 2'b10 : 2'b00;
        b_q.push_back(be);
        aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst;
        #1;
        cyc = 0;
        while (!aw_ready_o && cyc < 100) begin @(negedge clk); #1; cyc++; end
        check("aw_ready", 64'(aw_ready_o), 64'd1);
        @(negedge clk);
        aw_valid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            w_valid = 1'b1; w_data = wd[i]; w_strb = ws[i]; w_last = (i == nbeats - 1);
            #1;
            cyc = 0;
            while (!w_ready_o && cyc < 100) begin @(negedge clk); #1; cyc++; end
            check("w_ready", 64'(w_ready_o), 64'd1);
            if (!err) begin
                tmp = model.exists(idx) ? model[idx] : 64'd0;
                for (int j = 0; j < 8; j++) begin
                    if (ws[i][j]) tmp[8*j +: 8] = wd[i][8*j +: 8];
                end
                model[idx] = tmp;
            end
            if (burst != 2'b00) idx = (idx + 1) % NW;
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
        #1;
        cyc = 0;
        while (!b_valid_o && cyc < 100) begin @(negedge clk); #1; cyc++; end
        check("b_valid", 64'(b_valid_o), 64'd1);
        be = b_q.pop_front();
        check("b_id", 64'(b_id_o), 64'(be.id));
        check("b_resp", 64'(b_resp_o), 64'(be.resp));
        @(negedge clk);
        b_ready = 1'b0;
        #1;
        check("b_done", 64'(b_valid_o), 64'd0);
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input int stall_beat, input int stall_cyc);
        int     idx;
        int     cyc;
        bit     err;
        r_exp_t re;
        err = addr_err(addr);
        idx = word_idx(addr);
        for (int b = 0; b <= int'(len); b++) begin
            re.id   = id;
            re.data = err ? 64'd0 : model[idx];
            re.resp = err ? 2'b10 : 2'b00;
            re.last = (b == int'(len));
            r_q.push_back(re);
            if (burst != 2'b00) idx = (idx + 1) % NW;
        end
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst;
        #1;
        cyc = 0;
        while (!ar_ready_o && cyc < 100) begin @(negedge clk); #1; cyc++; end
        check("ar_ready", 64'(ar_ready_o), 64'd1);
        @(negedge clk);
        ar_valid = 1'b0;
        #1;
        check("r_first_latency", 64'(r_valid_o), 64'd1);
        for (int b = 0; b <= int'(len); b++) begin
            cyc = 0;
            while (!r_valid_o && cyc < 100) begin @(negedge clk); #1; cyc++; end
            check("r_valid", 64'(r_valid_o), 64'd1);
            if (b == stall_beat) begin
                r_ready = 1'b0;
                repeat (stall_cyc) begin
                    @(negedge clk); #1;
                    check("r_stall_valid", 64'(r_valid_o), 64'd1);
                    check("r_stall_data", r_data_o, r_q[0].data);
                    check("r_stall_last", 64'(r_last_o), 64'(r_q[0].last));
                end
            end
            re = r_q.pop_front();
            r_ready = 1'b1;
            check("r_id", 64'(r_id_o), 64'(re.id));
            check("r_data", r_data_o, re.data);
            check("r_resp", 64'(r_resp_o), 64'(re.resp));
            check("r_last", 64'(r_last_o), 64'(re.last));
            @(negedge clk); #1;
        end
        r_ready = 1'b0;
        check("r_done", 64'(r_valid_o), 64'd0);
    endtask

    initial begin
        n_asserts = 0; n_fail = 0;
        rst = 1'b1;
        aw_valid = 1'b0; aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = '0;
        w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; b_ready = 1'b0;
        ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = '0; r_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 8'hFF; end

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_aw_ready", 64'(aw_ready_o), 64'd0);
        check("rst_ar_ready", 64'(ar_ready_o), 64'd0);
        check("rst_w_ready", 64'(w_ready_o), 64'd0);
        check("rst_b_valid", 64'(b_valid_o), 64'd0);
        check("rst_r_valid", 64'(r_valid_o), 64'd0);
        check("rst_r_last", 64'(r_last_o), 64'd0);
        check("rst_r_data", r_data_o, 64'd0);
        check("rst_b_id_resp", 64'({b_id_o, b_resp_o, r_id_o, r_resp_o}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_aw_ready", 64'(aw_ready_o), 64'd1);
        check("idle_ar_ready", 64'(ar_ready_o), 64'd1);
        @(negedge clk);

        // basic INCR burst write then read
        wd[0] = 64'h1111; wd[1] = 64'h2222;
        do_write(4'd3, 64'h10, 8'd1, 2'b01, 2);
        do_read(4'd3, 64'h10, 8'd1, 2'b01, -1, 0);

        // partial strobe over an all-ones word
        wd[0] = '1;
        do_write(4'd1, 64'h0, 8'd0, 2'b01, 1);
        wd[0] = 64'h0; ws[0] = 8'h0F;
        do_write(4'd1, 64'h0, 8'd0, 2'b01, 1);
        ws[0] = 8'hFF;
        do_read(4'd2, 64'h0, 8'd0, 2'b01, -1, 0);

        // R backpressure held for three cycles on beat 1
        for (int i = 0; i < 4; i++) wd[i] = 64'hA000_0000_0000_0040 + 64'(i);
        do_write(4'd4, 64'h40, 8'd3, 2'b01, 4);
        do_read(4'd5, 64'h40, 8'd3, 2'b01, 1, 3);

        // index wraps from the top word to word 0
        wd[0] = 64'hAAAA_5555_0000_0FFF; wd[1] = 64'h5555_AAAA_0000_0000;
        do_write(4'd6, 64'((NW - 1) * 8), 8'd1, 2'b01, 2);
        do_read(4'd6, 64'((NW - 1) * 8), 8'd1, 2'b01, -1, 0);

        // FIXED burst keeps one index; reserved burst behaves as INCR
        wd[0] = 64'hC0C0; wd[1] = 64'hD0D0;
        do_write(4'd7, 64'h200, 8'd1, 2'b00, 2);
        do_read(4'd7, 64'h200, 8'd1, 2'b00, -1, 0);
        wd[0] = 64'hE1; wd[1] = 64'hE2;
        do_write(4'd7, 64'h280, 8'd1, 2'b11, 2);
        do_read(4'd7, 64'h280, 8'd1, 2'b01, -1, 0);

        // early w_last and beats beyond len
        wd[0] = 64'h3000; wd[1] = 64'h3001; wd[2] = 64'h3002;
        do_write(4'd8, 64'h300, 8'd3, 2'b01, 2);
        do_write(4'd8, 64'h380, 8'd0, 2'b01, 3);
        do_read(4'd8, 64'h300, 8'd1, 2'b01, -1, 0);
        do_read(4'd8, 64'h380, 8'd2, 2'b01, -1, 0);

        // data for the mid-read reset
        for (int i = 0; i < 8; i++) wd[i] = 64'hB100_0000_0000_0000 + 64'(i);
        do_write(4'd9, 64'h100, 8'd7, 2'b01, 8);

        // arbitration: first tie after reset goes to read, next tie to write
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        aw_valid = 1'b1; aw_id = 4'd5; aw_addr = 64'h10; aw_len = 8'd0; aw_burst = 2'b01;
        ar_valid = 1'b1; ar_id = 4'd6; ar_addr = 64'h10; ar_len = 8'd0; ar_burst = 2'b01;
        #1;
        check("tie1_ar_ready", 64'(ar_ready_o), 64'd1);
        check("tie1_aw_ready", 64'(aw_ready_o), 64'd0);
        @(negedge clk);
        ar_valid = 1'b0;
        #1;
        check("tie1_r_valid", 64'(r_valid_o), 64'd1);
        check("tie1_r_id", 64'(r_id_o), 64'd6);
        check("tie1_r_data", r_data_o, model[2]);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0; ar_valid = 1'b1; ar_id = 4'd7;
        #1;
        check("tie2_aw_ready", 64'(aw_ready_o), 64'd1);
        check("tie2_ar_ready", 64'(ar_ready_o), 64'd0);
        @(negedge clk);
        aw_valid = 1'b0;
        w_valid = 1'b1; w_data = 64'h5555; w_strb = 8'hFF; w_last = 1'b1;
        #1;
        check("tie2_w_ready", 64'(w_ready_o), 64'd1);
        model[2] = 64'h5555;
        @(negedge clk);
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        check("tie2_b_valid", 64'(b_valid_o), 64'd1);
        check("tie2_b_id", 64'(b_id_o), 64'd5);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        #1;
        check("tie2_ar_after_b", 64'(ar_ready_o), 64'd1);
        @(negedge clk);
        ar_valid = 1'b0;
        #1;
        check("raw_r_id", 64'(r_id_o), 64'd7);
        check("raw_r_data", r_data_o, model[2]);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        #1;
        check("raw_r_done", 64'(r_valid_o), 64'd0);

        // reset while beat 2 of an 8-beat read is pending
        ar_valid = 1'b1; ar_id = 4'd9; ar_addr = 64'h100; ar_len = 8'd7; ar_burst = 2'b01;
        #1;
        check("mid_ar_ready", 64'(ar_ready_o), 64'd1);
        @(negedge clk);
        ar_valid = 1'b0; r_ready = 1'b1;
        #1;
        check("mid_beat0", r_data_o, model[32]);
        @(negedge clk); #1;
        check("mid_beat1", r_data_o, model[33]);
        @(negedge clk);
        r_ready = 1'b0;
        #1;
        check("mid_beat2", r_data_o, model[34]);
        check("mid_beat2_last", 64'(r_last_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_r_valid", 64'(r_valid_o), 64'd0);
        check("mid_rst_r_data", r_data_o, 64'd0);
        check("mid_rst_ar_ready", 64'(ar_ready_o), 64'd1);
        do_read(4'd10, 64'h10, 8'd0, 2'b01, -1, 0);
        check("mid_rst_no_extra_r", 64'(r_q.size()), 64'd0);

        // out-of-range address: SLVERR with the error option, aliasing without it
        do_read(4'd11, 64'(NW * 8), 8'd0, 2'b01, -1, 0);
        wd[0] = 64'h7777;
        do_write(4'd12, 64'h8, 8'd0, 2'b01, 1);
        wd[0] = 64'h9999;
        do_write(4'd12, 64'(NW * 8 + 8), 8'd0, 2'b01, 1);
        do_read(4'd12, 64'h8, 8'd0, 2'b01, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
